// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control for the 32-bit single-bus datapath.
// Define CTRL_MEM_WAIT_EN to let T1 stall in TW until mem_ready is seen.
module control_sequencer #(
    parameter logic [4:0] NONE_SEL = 5'd31
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [4:0]  bus_sel,
    output logic [15:0] reg_in,
    output logic        pc_in,
    output logic        ir_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        y_in,
    output logic        z_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic        inc_pc,
    output logic        read,
    output logic [4:0]  alu_op,
    output logic        instr_done,
    output logic        halted
);
    typedef enum logic [3:0] {IDLE, T0, T1, TW, T2, T3, T4, T5, T6, HALT} state_t;
    localparam logic [4:0] OP_HALT = 5'd27;
    state_t      r_state;
    logic [4:0]  w_op;
    logic [3:0]  w_ra, w_rb, w_rc;
    logic        w_alu, w_md;
    logic        w_unused;
    assign w_op     = ir[31:27];
    assign w_ra     = ir[26:23];
    assign w_rb     = ir[22:19];
    assign w_rc     = ir[18:15];
    assign w_alu    = (w_op >= 5'd3) && (w_op <= 5'd11);
    assign w_md     = (w_op == 5'd15) || (w_op == 5'd16);
    assign w_unused = &{1'b0, ir[14:0]};
    always_ff @(posedge clk or posedge clear) begin
        if (clear) r_state <= IDLE;
        else begin
            case (r_state)
                IDLE:    r_state <= start ? T0 : IDLE;
                T0:      r_state <= T1;
`ifdef CTRL_MEM_WAIT_EN
                T1:      r_state <= mem_ready ? T2 : TW;
`else
                T1:      r_state <= T2;
`endif
                TW:      r_state <= mem_ready ? T2 : TW;
                T2:      r_state <= T3;
                T3:      r_state <= (w_alu || w_md) ? T4 : (w_op == OP_HALT) ? HALT : T0;
                T4:      r_state <= T5;
                T5:      r_state <= w_md ? T6 : T0;
                T6:      r_state <= T0;
                HALT:    r_state <= HALT;
                default: r_state <= IDLE;
            endcase
        end
    end
    // Decoded combinationally so T3/T4 see the ir loaded at the end of T2.
    always_comb begin
        bus_sel    = NONE_SEL;
        reg_in     = '0;
        pc_in      = 1'b0;
        ir_in      = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        inc_pc     = 1'b0;
        read       = 1'b0;
        alu_op     = '0;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (r_state)
            T0: begin
                bus_sel = 5'd20;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                z_in    = 1'b1;
            end
            T1: begin
                bus_sel = 5'd19;
                pc_in   = 1'b1;
                read    = 1'b1;
                mdr_in  = 1'b1;
            end
            TW: begin
                read   = 1'b1;
                mdr_in = 1'b1;
            end
            T2: begin
                bus_sel = 5'd21;
                ir_in   = 1'b1;
            end
            T3: begin
                bus_sel    = w_alu ? {1'b0, w_rb} : w_md ? {1'b0, w_ra} : NONE_SEL;
                y_in       = w_alu || w_md;
                instr_done = !w_alu && !w_md && (w_op != OP_HALT);
            end
            T4: begin
                bus_sel = w_alu ? {1'b0, w_rc} : {1'b0, w_rb};
                alu_op  = w_op;
                z_in    = 1'b1;
            end
            T5: begin
                bus_sel    = 5'd19;
                reg_in     = w_alu ? 16'd1 << w_ra : 16'd0;
                instr_done = w_alu;
                lo_in      = !w_alu;
            end
            T6: begin
                bus_sel    = 5'd18;
                hi_in      = 1'b1;
                instr_done = 1'b1;
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end
endmodule
